// File: rtl/tia_hsync_ctl.sv
// Horizontal line sequencer for the TIA.
// One line is 57 counts of 4 color-clock phases (228 color clocks).
// From that count it sequences the HBLANK, HSYNC, RDY (WSYNC halt) and
// HMOVE-extended-blank latches, and it emits a one-cycle line-start pulse.
// Every output comes straight from a register.
module tia_hsync_ctl (
  input  logic       clk,
  input  logic       reset,
  input  logic       wsync,
  input  logic       rsync,
  input  logic       hmove,
  output logic [5:0] hc,
  output logic [1:0] phase,
  output logic       hblank,
  output logic       hsync,
  output logic       rdy,
  output logic       hmove_latch,
  output logic       line_start
);

  // Line geometry and decode points. Each point is the hc value that is
  // entered together with phase 0.
  localparam logic [5:0] HC_LAST        = 6'd56;
  localparam logic [5:0] HC_HSYNC_SET   = 6'd4;
  localparam logic [5:0] HC_HSYNC_CLR   = 6'd8;
  localparam logic [5:0] HC_HBLANK_END  = 6'd17;
  localparam logic [5:0] HC_HBLANK_LATE = 6'd19;

  // Registered state
  logic [5:0] hc_reg, hc_next;
  logic [1:0] phase_reg, phase_next;
  logic       hblank_reg, hblank_next;
  logic       hsync_reg, hsync_next;
  logic       rdy_reg, rdy_next;
  logic       hmove_latch_reg, hmove_latch_next;
  logic       line_start_reg, line_start_next;

  // Decode of the count value that the next edge will enter
  logic wrap;
  logic restart;
  logic enter_phase0;

  // Decide where the counter goes on the next edge. The line restarts on a
  // natural wrap out of (56,3) or on an RSYNC strobe.
  always_comb begin
    wrap       = (hc_reg == HC_LAST) && (phase_reg == 2'd3);
    restart    = wrap || rsync;
    phase_next = phase_reg + 2'd1;
    hc_next    = hc_reg;
    if (restart) begin
      phase_next = 2'd0;
      hc_next    = 6'd0;
    end else if (phase_reg == 2'd3) begin
      hc_next = hc_reg + 6'd1;
    end
    enter_phase0 = (phase_next == 2'd0) && !restart;
  end

  // Next-state logic for the line-level latches. A strobe that coincides with
  // the line-start edge takes priority over the clear that line start applies.
  always_comb begin
    line_start_next  = restart;

    // HSYNC spans counts 4..7 (16 color clocks). A restart drops it at once.
    hsync_next = hsync_reg;
    if (restart) begin
      hsync_next = 1'b0;
    end else if (enter_phase0 && hc_next == HC_HSYNC_SET) begin
      hsync_next = 1'b1;
    end else if (enter_phase0 && hc_next == HC_HSYNC_CLR) begin
      hsync_next = 1'b0;
    end

    // HBLANK ends at count 17, or at count 19 when HMOVE extends it. The
    // choice at 17 uses the latch value from the cycle before that edge.
    // A late HMOVE never re-asserts blank, because nothing sets blank
    // except a line start.
    hblank_next = hblank_reg;
    if (restart) begin
      hblank_next = 1'b1;
    end else if (enter_phase0 && hc_next == HC_HBLANK_END && !hmove_latch_reg) begin
      hblank_next = 1'b0;
    end else if (enter_phase0 && hc_next == HC_HBLANK_LATE) begin
      hblank_next = 1'b0;
    end

    // WSYNC halts the CPU until a line start. If the strobe arrives on the
    // line-start edge, the halt covers the whole new line.
    rdy_next = rdy_reg;
    if (wsync) begin
      rdy_next = 1'b0;
    end else if (restart) begin
      rdy_next = 1'b1;
    end

    // The HMOVE latch is held until the next line start. A strobe on the
    // line-start edge keeps the latch set for the new line.
    hmove_latch_next = hmove_latch_reg;
    if (hmove) begin
      hmove_latch_next = 1'b1;
    end else if (restart) begin
      hmove_latch_next = 1'b0;
    end
  end

  // State register. Reset overrides every strobe. After reset the counter sits
  // at (0,0) with no line-start pulse, so the first pulse comes at the next wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_reg          <= 6'd0;
      phase_reg       <= 2'd0;
      hblank_reg      <= 1'b1;
      hsync_reg       <= 1'b0;
      rdy_reg         <= 1'b1;
      hmove_latch_reg <= 1'b0;
      line_start_reg  <= 1'b0;
    end else begin
      hc_reg          <= hc_next;
      phase_reg       <= phase_next;
      hblank_reg      <= hblank_next;
      hsync_reg       <= hsync_next;
      rdy_reg         <= rdy_next;
      hmove_latch_reg <= hmove_latch_next;
      line_start_reg  <= line_start_next;
    end
  end

  // Outputs are driven directly by the registers
  assign hc          = hc_reg;
  assign phase       = phase_reg;
  assign hblank      = hblank_reg;
  assign hsync       = hsync_reg;
  assign rdy         = rdy_reg;
  assign hmove_latch = hmove_latch_reg;
  assign line_start  = line_start_reg;

endmodule

// File: tb/tb_tia_hsync_ctl.sv
// Directed testbench for tia_hsync_ctl. Expected values are hand-computed.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at the same point.
module tb_tia_hsync_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wsync = 1'b0;
  logic       rsync = 1'b0;
  logic       hmove = 1'b0;
  logic [5:0] hc;
  logic [1:0] phase;
  logic       hblank;
  logic       hsync;
  logic       rdy;
  logic       hmove_latch;
  logic       line_start;

  int passed = 0;
  int total  = 0;

  tia_hsync_ctl dut (
    .clk         (clk),
    .reset       (reset),
    .wsync       (wsync),
    .rsync       (rsync),
    .hmove       (hmove),
    .hc          (hc),
    .phase       (phase),
    .hblank      (hblank),
    .hsync       (hsync),
    .rdy         (rdy),
    .hmove_latch (hmove_latch),
    .line_start  (line_start)
  );

  // Color clock
  always #5 clk = ~clk;

  // One comparison: count it, then report it if it does not match
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s did not match", tag);
    end
  endtask

  // Advance one edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the counter shows (h,p), with a cycle budget
  task automatic goto(input int h, input int p, input string tag);
    int n;
    n = 0;
    while (!(hc == h && phase == p) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk(tag, 300, 0);
  endtask

  // Count cycles until the next line_start pulse, with a cycle budget
  task automatic cycles_to_ls(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!line_start && n < 400);
  endtask

  initial begin
    int n;
    int hs_cnt;
    int hb_cnt;
    int hs_first;

    // Reset, then check the reset values
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_hc", hc, 0);
    chk("rst_phase", phase, 0);
    chk("rst_hblank", hblank, 1);
    chk("rst_hsync", hsync, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_hmove_latch", hmove_latch, 0);
    chk("rst_line_start", line_start, 0);
    $display("step reset: hc=%0d phase=%0d hblank=%0d", hc, phase, hblank);

    // Free run: the first line_start comes 228 cycles after reset
    cycles_to_ls(n);
    chk("first_ls_period", n, 228);
    hs_cnt = 0;
    hb_cnt = 0;
    hs_first = -1;
    for (int i = 0; i < 228; i++) begin
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
      if (hblank) hb_cnt++;
      tick();
      if (i < 227) chk("ls_single_cycle", line_start, 0);
    end
    chk("free_ls_period", line_start, 1);
    chk("hsync_width", hs_cnt, 16);
    chk("hsync_start", hs_first, 16);
    chk("hblank_width", hb_cnt, 68);
    $display("step free run: hsync=%0d hblank=%0d cycles", hs_cnt, hb_cnt);

    // HMOVE extension: strobe at (10,2)
    goto(10, 2, "goto_10_2");
    hmove = 1'b1;
    tick();
    hmove = 1'b0;
    chk("hmove_latch_set", hmove_latch, 1);
    goto(18, 3, "goto_18_3");
    chk("hmove_hblank_18_3", hblank, 1);
    tick();
    chk("hmove_hblank_19_0", hblank, 0);
    goto(0, 0, "goto_0_0_a");
    chk("hmove_next_ls", line_start, 1);
    chk("hmove_latch_clear", hmove_latch, 0);
    goto(16, 3, "goto_16_3");
    chk("next_hblank_16_3", hblank, 1);
    tick();
    chk("next_hblank_17_0", hblank, 0);
    $display("step hmove: hblank ends at 19 with latch, then at 17");

    // WSYNC strobe at (30,1)
    goto(30, 1, "goto_30_1");
    wsync = 1'b1;
    tick();
    wsync = 1'b0;
    chk("wsync_rdy_low", rdy, 0);
    goto(56, 3, "goto_56_3_a");
    chk("wsync_rdy_56_3", rdy, 0);
    tick();
    chk("wsync_ls", line_start, 1);
    chk("wsync_rdy_release", rdy, 1);
    $display("step wsync mid-line: rdy released at line start");

    // WSYNC strobe in the cycle before the wrap holds the halt one extra line
    goto(56, 3, "goto_56_3_b");
    wsync = 1'b1;
    tick();
    wsync = 1'b0;
    chk("wsync_wrap_ls", line_start, 1);
    chk("wsync_wrap_rdy0", rdy, 0);
    tick();
    goto(56, 3, "goto_56_3_c");
    chk("wsync_wrap_rdy_line", rdy, 0);
    tick();
    chk("wsync_wrap_rdy_release", rdy, 1);
    $display("step wsync at wrap: rdy held for a full line");

    // RSYNC during hsync, strobe at (6,2)
    goto(6, 2, "goto_6_2");
    chk("hsync_high_6_2", hsync, 1);
    rsync = 1'b1;
    tick();
    rsync = 1'b0;
    chk("rsync_hc", hc, 0);
    chk("rsync_phase", phase, 0);
    chk("rsync_hsync", hsync, 0);
    chk("rsync_hblank", hblank, 1);
    chk("rsync_ls", line_start, 1);
    cycles_to_ls(n);
    chk("rsync_period", n, 228);
    $display("step rsync mid-hsync: restart, next line after %0d cycles", n);

    // Reset mid-operation with strobes active at (25,3)
    goto(25, 3, "goto_25_3");
    hmove = 1'b1;
    wsync = 1'b1;
    reset = 1'b1;
    tick();
    hmove = 1'b0;
    wsync = 1'b0;
    reset = 1'b0;
    chk("mrst_hc", hc, 0);
    chk("mrst_phase", phase, 0);
    chk("mrst_hblank", hblank, 1);
    chk("mrst_hsync", hsync, 0);
    chk("mrst_rdy", rdy, 1);
    chk("mrst_hmove_latch", hmove_latch, 0);
    chk("mrst_line_start", line_start, 0);
    $display("step reset mid-line: outputs at reset values");

    // RSYNC, WSYNC and HMOVE together at (40,0)
    goto(40, 0, "goto_40_0");
    rsync = 1'b1;
    wsync = 1'b1;
    hmove = 1'b1;
    tick();
    rsync = 1'b0;
    wsync = 1'b0;
    hmove = 1'b0;
    chk("sim_ls", line_start, 1);
    chk("sim_hc", hc, 0);
    chk("sim_rdy", rdy, 0);
    chk("sim_hmove_latch", hmove_latch, 1);
    goto(18, 3, "goto_18_3_b");
    chk("sim_hblank_18_3", hblank, 1);
    tick();
    chk("sim_hblank_19_0", hblank, 0);
    goto(0, 0, "goto_0_0_b");
    chk("sim_next_ls", line_start, 1);
    chk("sim_rdy_release", rdy, 1);
    chk("sim_latch_clear", hmove_latch, 0);
    $display("step simultaneous strobes: restart with halt and extended blank");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tia_hsync_ctl.md
# tia_hsync_ctl

Horizontal timing sequencer for the TIA. It divides the color clock into a four-phase, 57-count horizontal line of 228 color clocks. From that count it drives the set/reset sequencing for the line-level latches: HBLANK, HSYNC, the WSYNC-controlled RDY, and the HMOVE extended-blank latch. It sits between the register-write strobe decoder and the playfield, object and video-output logic, which consume its levels and its line-start pulse.

## Interface

- No parameters. Line geometry is fixed: 57 counts × 4 phases = 228 color clocks.
- clk  in  1  color clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- wsync  in  1  one-cycle strobe from the WSYNC register write; halts the CPU until the next line start.
- rsync  in  1  one-cycle strobe from the RSYNC register write; forces a line restart.
- hmove  in  1  one-cycle strobe from the HMOVE register write; requests extended blank on the current line.
- hc  out  6  horizontal count, 0..56.
- phase  out  2  color-clock phase within the count, 0..3.
- hblank  out  1  horizontal blank level.
- hsync  out  1  horizontal sync level.
- rdy  out  1  CPU ready; 0 halts the CPU.
- hmove_latch  out  1  HMOVE latch state.
- line_start  out  1  one-cycle pulse in the first cycle of each line.

## Operation

- Counter
  - {hc, phase} advances every clk: phase 0→3, and hc increments when phase wraps.
  - After (56,3) it wraps to (0,0).
  - hc never exceeds 56; values 57..63 are unreachable.
- Line start
  - Occurs when the counter enters (0,0), either by natural wrap or by rsync.
  - line_start=1 for exactly that cycle.
  - hblank=1, hsync=0, rdy=1 (unless overridden as described under wsync), hmove_latch=0 (unless overridden as described under hmove).
- HSYNC: set on entering (4,0); reset on entering (8,0). Asserted for 16 color clocks.
- HBLANK
  - Set at line start.
  - Reset on entering (17,0) if hmove_latch=0 in the cycle before that edge.
  - Otherwise reset on entering (19,0). That is 68 or 76 color clocks of blank.
- wsync: rdy=0 from the cycle after the strobe until line start.
- hmove: hmove_latch=1 from the cycle after the strobe until the next line start.
- rsync: the counter enters (0,0) on the next edge, regardless of the current count. All line-start effects apply.
- All outputs are registered and change only on clk edges. There are no combinational paths from inputs to outputs.

## Timing

- Reset values, in the cycle after reset is sampled high:
  - hc=0, phase=0, hblank=1, hsync=0, rdy=1, hmove_latch=0, line_start=0.
  - The first line_start occurs at the next wrap (228 cycles after reset is released).
- Reset wins over every strobe. Reset asserted mid-line, mid-hsync or mid-wsync halt returns every output to its reset value on the next edge.
- Strobe latency: one cycle for each of wsync, rsync and hmove.
- Decode points apply on the edge that enters the listed {hc, phase}. For example, hsync reads 1 in the first cycle where hc=4, phase=0.
- Simultaneous events:
  - **wsync with line start:** a wsync strobe sampled on the edge that enters line start wins over the release. rdy=0 for the whole new line, until the following line start.
  - **hmove with line start:** an hmove strobe sampled on the line-start edge wins over the clear. hmove_latch=1 and that line's hblank ends at (19,0).
  - **hmove after the decision point:** an hmove strobe arriving after the (17,0) decision sets the latch but does not re-assert hblank on the current line. The latch clears at the next line start.
  - **rsync with wsync:** both apply. The counter restarts and rdy=0 until the line start after the forced one.
  - **rsync during hsync:** hsync drops to 0 on the restart edge.
  - **rsync at (56,3):** indistinguishable from a natural wrap.
- Line period without rsync: exactly 228 cycles between line_start pulses.

## Test plan

- **Reset and free run:** reset 1 cycle, run 500 cycles → line_start pulses exactly 228 cycles apart; hsync high 16 cycles starting at (4,0); hblank high 68 cycles from each line start.
- **HMOVE extension:** hmove strobe at (10,2) → hblank stays 1 through (18,3) and falls entering (19,0). Next line: hmove_latch=0 and hblank falls at (17,0).
- **WSYNC halt:**
  - Strobe at (30,1) → rdy=0 from the next cycle until line start, then 1.
  - Strobe in the cycle before wrap → rdy stays 0 for one full additional line.
- **RSYNC mid-hsync:** strobe at (6,2) → next cycle hc=0, phase=0, hsync=0, hblank=1, line_start=1. The next line_start follows 228 cycles later.
- **Reset mid-operation:** hmove and wsync active at (25,3), assert reset → next cycle all outputs at reset values, rdy=1, hmove_latch=0.
- **Simultaneous strobes:** rsync+wsync+hmove in the same cycle at (40,0) → restart line with rdy=0 and hmove_latch=1; hblank falls at (19,0); rdy returns 1 at the following line start.
